alarm_delay_timer: RTL and testbench

//   Responder side of the security FSM's timer handshake. The FSM raises t_on to

---
 rtl/alarm_delay_timer.sv | 109 ++++++++++
 tb/tb_alarm_delay_timer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alarm_delay_timer.sv
// Delay timer that answers the security FSM's t_on request with t_done.
// The delay is a loadable tick count. A prescaler divides clk into ticks,
// and pause freezes the countdown. Completed delays are counted, saturating at 255.
module alarm_delay_timer #(
  parameter int DELAY_W  = 8,
  parameter int PRESCALE = 1,
  parameter int PS_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               t_on,
  input  logic               pause,
  input  logic [DELAY_W-1:0] delay,
  output logic               t_done,
  output logic               busy,
  output logic [DELAY_W-1:0] remaining,
  output logic [7:0]         expire_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] rem_q, rem_d;
  logic [PS_W-1:0]    ps_q, ps_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               done_q, busy_q;
  logic               tick;

  assign tick = (ps_q == PS_LAST) && !pause;

  // State, counters and registered status flags; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ps_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d == RUN);
    end
  end

  // Next state and counter updates. A dropped t_on wins over pause and over the final tick.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        rem_d = '0;
        ps_d  = '0;
        if (t_on) begin
          state_d = RUN;
          rem_d   = (delay == '0) ? DELAY_W'(1) : delay;
        end
      end
      RUN: begin
        if (!t_on) begin
          state_d = IDLE;
          rem_d   = '0;
          ps_d    = '0;
        end else if (!pause) begin
          if (tick) begin
            ps_d = '0;
            if (rem_q > DELAY_W'(1)) begin
              rem_d = rem_q - DELAY_W'(1);
            end else begin
              rem_d   = '0;
              state_d = DONE;
              if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
          end else begin
            ps_d = ps_q + PS_W'(1);
          end
        end
      end
      DONE: begin
        rem_d = '0;
        ps_d  = '0;
        if (!t_on) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
        ps_d    = '0;
      end
    endcase
  end

  assign t_done     = done_q;
  assign busy       = busy_q;
  assign remaining  = rem_q;
  assign expire_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_delay_timer.sv
// Directed bench for alarm_delay_timer. One instance uses PRESCALE=1 and one uses PRESCALE=4.
// Each step queues the expected outputs and checks them one clock later.
module tb_alarm_delay_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       t_on1 = 1'b0, t_on4 = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] delay = 8'd0;
  logic       t_done1, busy1, t_done4, busy4;
  logic [7:0] rem1, cnt1, rem4, cnt4;

  typedef struct {
    string      tag;
    bit         sel4;
    bit         busy;
    bit         done;
    logic [7:0] rem;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0, passed = 0, fails = 0;
  logic [7:0] ecnt;

  alarm_delay_timer #(.DELAY_W(8), .PRESCALE(1), .PS_W(8)) dut1 (
    .clk(clk), .reset(reset), .t_on(t_on1), .pause(pause), .delay(delay),
    .t_done(t_done1), .busy(busy1), .remaining(rem1), .expire_cnt(cnt1));

  alarm_delay_timer #(.DELAY_W(8), .PRESCALE(4), .PS_W(8)) dut4 (
    .clk(clk), .reset(reset), .t_on(t_on4), .pause(pause), .delay(delay),
    .t_done(t_done4), .busy(busy4), .remaining(rem4), .expire_cnt(cnt4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit sel4, input bit b, input bit d,
                      input logic [7:0] r, input logic [7:0] c);
    exp_t e;
    e.tag = tag; e.sel4 = sel4; e.busy = b; e.done = d; e.rem = r; e.cnt = c;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      check("queue_empty", 8'd1, 8'd0);
      return;
    end
    e = q.pop_front();
    check({e.tag, ".busy"},   e.sel4 ? {7'd0, busy4}   : {7'd0, busy1},   {7'd0, e.busy});
    check({e.tag, ".t_done"}, e.sel4 ? {7'd0, t_done4} : {7'd0, t_done1}, {7'd0, e.done});
    check({e.tag, ".rem"},    e.sel4 ? rem4 : rem1, e.rem);
    check({e.tag, ".cnt"},    e.sel4 ? cnt4 : cnt1, e.cnt);
  endtask

  // One clock edge: queue the expectation, take the edge, compare 1ns later.
  task automatic step(input string tag, input bit sel4, input bit b, input bit d,
                      input logic [7:0] r, input logic [7:0] c);
    push(tag, sel4, b, d, r, c);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    // Reset state on both instances.
    repeat (2) @(posedge clk);
    #1;
    push("rst1", 1'b0, 0, 0, 8'd0, 8'd0); pop_check();
    push("rst4", 1'b1, 0, 0, 8'd0, 8'd0); pop_check();
    reset = 1'b0;
    step("idle", 1'b0, 0, 0, 8'd0, 8'd0);

    // Test 1: delay 5. A delay change after the load edge must be ignored.
    delay = 8'd5; t_on1 = 1'b1;
    step("t1_load", 1'b0, 1, 0, 8'd5, 8'd0);
    delay = 8'd200;
    for (int i = 4; i >= 1; i--) step("t1_run", 1'b0, 1, 0, 8'(i), 8'd0);
    step("t1_done", 1'b0, 0, 1, 8'd0, 8'd1);
    step("t1_hold", 1'b0, 0, 1, 8'd0, 8'd1);
    t_on1 = 1'b0;
    step("t1_idle", 1'b0, 0, 0, 8'd0, 8'd1);

    // Test 3: delay 6 with pause held across edges 2..4.
    delay = 8'd6; t_on1 = 1'b1;
    step("t3_load", 1'b0, 1, 0, 8'd6, 8'd1);
    step("t3_e1", 1'b0, 1, 0, 8'd5, 8'd1);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) step("t3_pause", 1'b0, 1, 0, 8'd5, 8'd1);
    pause = 1'b0;
    for (int i = 4; i >= 1; i--) step("t3_run", 1'b0, 1, 0, 8'(i), 8'd1);
    step("t3_done", 1'b0, 0, 1, 8'd0, 8'd2);
    t_on1 = 1'b0;
    step("t3_idle", 1'b0, 0, 0, 8'd0, 8'd2);

    // Test 4: abort at edge 3, then restart and abort again with pause high.
    delay = 8'd8; t_on1 = 1'b1;
    step("t4_load", 1'b0, 1, 0, 8'd8, 8'd2);
    step("t4_e1", 1'b0, 1, 0, 8'd7, 8'd2);
    step("t4_e2", 1'b0, 1, 0, 8'd6, 8'd2);
    t_on1 = 1'b0;
    step("t4_abort", 1'b0, 0, 0, 8'd0, 8'd2);
    t_on1 = 1'b1;
    step("t4_reload", 1'b0, 1, 0, 8'd8, 8'd2);
    step("t4_re1", 1'b0, 1, 0, 8'd7, 8'd2);
    t_on1 = 1'b0; pause = 1'b1;
    step("t4_abort_pause", 1'b0, 0, 0, 8'd0, 8'd2);
    pause = 1'b0;

    // Test 5: delay 0 acts as 1. Run past 256 completions to check saturation.
    delay = 8'd0;
    ecnt = 8'd2;
    for (int i = 0; i < 256; i++) begin
      t_on1 = 1'b1;
      step("t5_load", 1'b0, 1, 0, 8'd1, ecnt);
      ecnt = (ecnt == 8'd255) ? 8'd255 : ecnt + 8'd1;
      step("t5_done", 1'b0, 0, 1, 8'd0, ecnt);
      t_on1 = 1'b0;
      step("t5_idle", 1'b0, 0, 0, 8'd0, ecnt);
    end
    check("t5_sat", cnt1, 8'd255);

    // Test 6: an asynchronous reset mid-RUN, then mid-DONE. A held t_on restarts afterwards.
    delay = 8'd5; t_on1 = 1'b1;
    step("t6_load", 1'b0, 1, 0, 8'd5, 8'd255);
    step("t6_e1", 1'b0, 1, 0, 8'd4, 8'd255);
    step("t6_e2", 1'b0, 1, 0, 8'd3, 8'd255);
    #2 reset = 1'b1;
    #1 push("t6_rst_run", 1'b0, 0, 0, 8'd0, 8'd0); pop_check();
    #1 reset = 1'b0;
    step("t6_fresh", 1'b0, 1, 0, 8'd5, 8'd0);
    for (int i = 4; i >= 1; i--) step("t6_run", 1'b0, 1, 0, 8'(i), 8'd0);
    step("t6_done", 1'b0, 0, 1, 8'd0, 8'd1);
    #2 reset = 1'b1;
    #1 push("t6_rst_done", 1'b0, 0, 0, 8'd0, 8'd0); pop_check();
    #1 reset = 1'b0;
    step("t6_fresh2", 1'b0, 1, 0, 8'd5, 8'd0);
    t_on1 = 1'b0;
    step("t6_idle", 1'b0, 0, 0, 8'd0, 8'd0);

    // Test 2: PRESCALE=4 with delay 3. remaining drops at edges 4 and 8, and DONE follows edge 12.
    delay = 8'd3; t_on4 = 1'b1;
    step("t2_load", 1'b1, 1, 0, 8'd3, 8'd0);
    for (int e = 1; e <= 11; e++)
      step("t2_run", 1'b1, 1, 0, (e < 4) ? 8'd3 : (e < 8) ? 8'd2 : 8'd1, 8'd0);
    step("t2_done", 1'b1, 0, 1, 8'd0, 8'd1);
    t_on4 = 1'b0;
    step("t2_idle", 1'b1, 0, 0, 8'd0, 8'd1);

    check("queue_drained", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog in case a wait hangs.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
